// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, debounce state encoding and code helpers for keypad_scan
// Contents: KEY_* code constants, deb_state_t, rc_to_code(), code_to_onehot(), code_is_single()
package keypad_pkg;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_0     = 4'd1;
    localparam logic [3:0] KEY_1     = 4'd2;
    localparam logic [3:0] KEY_2     = 4'd3;
    localparam logic [3:0] KEY_3     = 4'd4;
    localparam logic [3:0] KEY_4     = 4'd5;
    localparam logic [3:0] KEY_5     = 4'd6;
    localparam logic [3:0] KEY_6     = 4'd7;
    localparam logic [3:0] KEY_7     = 4'd8;
    localparam logic [3:0] KEY_8     = 4'd9;
    localparam logic [3:0] KEY_9     = 4'd10;
    localparam logic [3:0] KEY_STAR  = 4'd11;
    localparam logic [3:0] KEY_HASH  = 4'd12;
    localparam logic [3:0] KEY_MULTI = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DEB_REL   = 2'd3
    } deb_state_t;

    // Matrix position to key code: r0 = 1 2 3, r1 = 4 5 6, r2 = 7 8 9, r3 = * 0 #
    function automatic logic [3:0] rc_to_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'hA:    code = KEY_9;
            4'hC:    code = KEY_STAR;
            4'hD:    code = KEY_0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Digit codes map to bit (code - KEY_0); '*', '#' and non-key codes give zero
    function automatic logic [9:0] code_to_onehot(input logic [3:0] code);
        logic [9:0] oh;
        for (int i = 0; i < 10; i++) begin
            oh[i] = (code == 4'(i + 1));
        end
        return oh;
    endfunction

    function automatic logic code_is_single(input logic [3:0] code);
        return (code >= KEY_0) && (code <= KEY_HASH);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - press/release debounce FSM fed by one code per scan frame
// Ports: clk, rst (async, active-high); frame_valid/frame_code in (one result per frame);
//        keypad[9:0], key_star, key_hash (accepted key levels), key_press (one-clock pulse) out
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEB_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    input  logic [3:0] frame_code,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_press
);

    localparam int CW = $clog2(DEB_SCANS + 1);

    deb_state_t    state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          cnt_done;
    logic          single;

    // Saturating increment: the match count parks at DEB_SCANS instead of wrapping
    always_comb begin
        cnt_inc  = (cnt == CW'(DEB_SCANS)) ? cnt : cnt + CW'(1);
        cnt_done = (cnt_inc == CW'(DEB_SCANS));
        single   = code_is_single(frame_code);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= KEY_NONE;
            cnt       <= '0;
            keypad    <= '0;
            key_star  <= 1'b0;
            key_hash  <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (frame_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (single) begin
                            cand  <= frame_code;
                            cnt   <= CW'(1);
                            state <= ST_DEB_PRESS;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (frame_code == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_done) begin
                                cnt       <= '0;
                                state     <= ST_PRESSED;
                                keypad    <= code_to_onehot(cand);
                                key_star  <= (cand == KEY_STAR);
                                key_hash  <= (cand == KEY_HASH);
                                key_press <= 1'b1;
                            end
                        end else if (single) begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                        end else begin
                            cand  <= KEY_NONE;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        // Anything but the accepted key (including a different key) starts a release
                        if (frame_code != cand) begin
                            cnt   <= CW'(1);
                            state <= ST_DEB_REL;
                        end
                    end
                    ST_DEB_REL: begin
                        if (frame_code == cand) begin
                            cnt   <= '0;
                            state <= ST_PRESSED;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_done) begin
                                cnt      <= '0;
                                cand     <= KEY_NONE;
                                state    <= ST_IDLE;
                                keypad   <= '0;
                                key_star <= 1'b0;
                                key_hash <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x3 keypad column scanner with per-frame key decode and debounce
// Ports: clk, rst (async, active-high); key_row[3:0] in (async row sense);
//        key_col[2:0] out (one-hot column drive); keypad[9:0], key_star, key_hash, key_press out
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_HOLD = 2,
    parameter int DEB_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_press
);

    // SCAN_HOLD must be >= 2: the synchronizer needs one clock inside the new column
    // before the slot's last clock samples it, otherwise the previous column leaks in.
    localparam int HW = $clog2(SCAN_HOLD);

    logic [3:0]    row_sync;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;

    logic          slot_end;
    logic [1:0]    hit_cnt;
    logic [1:0]    hit_row;
    logic [2:0]    sum_cnt;
    logic [1:0]    tot_cnt;
    logic [3:0]    tot_code;
    logic          frame_valid;
    logic [3:0]    frame_code;

    // Key counts saturate at 2: anything beyond one key is simply MULTI
    always_comb begin
        slot_end = (hold_cnt == HW'(SCAN_HOLD - 1));
        hit_cnt  = 2'd0;
        hit_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_sync[r]) begin
                hit_row = 2'(r);
                if (hit_cnt != 2'd2) begin
                    hit_cnt = hit_cnt + 2'd1;
                end
            end
        end
        sum_cnt  = {1'b0, acc_cnt} + {1'b0, hit_cnt};
        tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        tot_code = (acc_cnt != 2'd0) ? acc_code : rc_to_code(hit_row, col_idx);
        frame_valid = slot_end && (col_idx == 2'd2);
        case (tot_cnt)
            2'd0:    frame_code = KEY_NONE;
            2'd1:    frame_code = tot_code;
            default: frame_code = KEY_MULTI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sync <= '0;
            hold_cnt <= '0;
            col_idx  <= 2'd0;
            key_col  <= 3'b001;
            acc_cnt  <= 2'd0;
            acc_code <= KEY_NONE;
        end else begin
            row_sync <= key_row;
            if (slot_end) begin
                hold_cnt <= '0;
                if (col_idx == 2'd2) begin
                    // Frame is handed to the debouncer on this same edge
                    col_idx  <= 2'd0;
                    key_col  <= 3'b001;
                    acc_cnt  <= 2'd0;
                    acc_code <= KEY_NONE;
                end else begin
                    col_idx  <= col_idx + 2'd1;
                    key_col  <= {key_col[1:0], 1'b0};
                    acc_cnt  <= tot_cnt;
                    acc_code <= tot_code;
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEB_SCANS (DEB_SCANS)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_code  (frame_code),
        .keypad      (keypad),
        .key_star    (key_star),
        .key_hash    (key_hash),
        .key_press   (key_press)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed table-driven bench for keypad_scan with a keypad matrix model
module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_press;

    // held[r*3+c] = key at row r, column c is pressed
    logic [11:0] held;

    int checks;
    int errors;
    int press_cnt;
    int excl_err;

    keypad_scan #(
        .SCAN_HOLD (2),
        .DEB_SCANS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .keypad    (keypad),
        .key_star  (key_star),
        .key_hash  (key_hash),
        .key_press (key_press)
    );

    assign key_row = {|(held[11:9] & key_col), |(held[8:6] & key_col),
                      |(held[5:3] & key_col),  |(held[2:0] & key_col)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_press) press_cnt++;
        if (($countones(keypad) + int'(key_star) + int'(key_hash)) > 1) excl_err++;
    end

    typedef struct {
        string      name;
        logic [11:0] held;
        logic [9:0] exp_keypad;
        logic       exp_star;
        logic       exp_hash;
        logic       exp_press;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [11:0] h);
        rst  = 1'b1;
        held = h;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        press_cnt = 0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        press_cnt = 0;
        excl_err  = 0;
        held      = '0;
        rst       = 1'b1;

        vecs[0]  = '{"none",     12'h000, 10'b0000000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"key5",     12'h010, 10'b0000100000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{"key1",     12'h001, 10'b0000000010, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{"key3",     12'h004, 10'b0000001000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{"key9",     12'h100, 10'b1000000000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{"key0",     12'h400, 10'b0000000001, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{"star",     12'h200, 10'b0000000000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{"hash",     12'h800, 10'b0000000000, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{"multi14",  12'h009, 10'b0000000000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"multi26",  12'h022, 10'b0000000000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"key8",     12'h080, 10'b0100000000, 1'b0, 1'b0, 1'b1};

        // Reset state and column rotation
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col", 32'(key_col), 32'h1);
        chk("rst_out", 32'({keypad, key_star, key_hash, key_press}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("col_e1", 32'(key_col), 32'h1);
        step(1);
        chk("col_e2", 32'(key_col), 32'h2);
        step(2);
        chk("col_e4", 32'(key_col), 32'h4);
        step(2);
        chk("col_e6", 32'(key_col), 32'h1);

        // Table: key held from frame start, accepted exactly at clock 18
        for (int i = 0; i < 11; i++) begin
            do_reset(vecs[i].held);
            step(17);
            chk({vecs[i].name, "_pre"}, 32'({keypad, key_star, key_hash, key_press}), 32'h0);
            step(1);
            chk({vecs[i].name, "_out"}, 32'({keypad, key_star, key_hash}),
                32'({vecs[i].exp_keypad, vecs[i].exp_star, vecs[i].exp_hash}));
            chk({vecs[i].name, "_press"}, 32'(key_press), 32'(vecs[i].exp_press));
            step(1);
            chk({vecs[i].name, "_pulse"}, 32'(key_press), 32'h0);
        end

        // Release of '5': cleared 18 clocks after the first empty frame starts
        do_reset(12'h010);
        step(18);
        held = '0;
        step(17);
        chk("rel5_hold", 32'(keypad), 32'h020);
        step(1);
        chk("rel5_clear", 32'(keypad), 32'h0);
        chk("rel5_presses", 32'(press_cnt), 32'd1);

        // Bounce '7': present, absent, then present for three frames
        do_reset(12'h040);
        step(6);
        held = '0;
        step(6);
        held = 12'h040;
        step(17);
        chk("b7_pre", 32'(keypad), 32'h0);
        step(1);
        chk("b7_acc", 32'(keypad), 32'h080);
        step(3);
        chk("b7_presses", 32'(press_cnt), 32'd1);

        // '1' and '9' together, then '9' released
        do_reset(12'h101);
        step(24);
        chk("m19_out", 32'(keypad), 32'h0);
        chk("m19_presses", 32'(press_cnt), 32'd0);
        held = 12'h001;
        step(17);
        chk("m19_pre", 32'(keypad), 32'h0);
        step(1);
        chk("m19_acc1", 32'(keypad), 32'h002);

        // '*' then '#': must pass through all-zero outputs
        do_reset(12'h200);
        step(18);
        chk("sh_star", 32'(key_star), 32'h1);
        held = 12'h800;
        step(17);
        chk("sh_star_hold", 32'(key_star), 32'h1);
        step(1);
        chk("sh_zero", 32'({keypad, key_star, key_hash}), 32'h0);
        step(17);
        chk("sh_hash_pre", 32'(key_hash), 32'h0);
        step(1);
        chk("sh_hash", 32'({keypad, key_star, key_hash, key_press}), 32'h3);
        step(1);
        chk("sh_presses", 32'(press_cnt), 32'd2);

        // Async reset mid-press, then full re-debounce of '0'
        do_reset(12'h400);
        step(18);
        chk("ar_acc", 32'(keypad), 32'h001);
        step(5);
        #2 rst = 1'b1;
        #1;
        chk("ar_clear", 32'({keypad, key_star, key_hash, key_press}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        press_cnt = 0;
        step(17);
        chk("ar_pre", 32'(keypad), 32'h0);
        step(1);
        chk("ar_reacc", 32'({keypad, key_press}), 32'h003);

        // Single dropped frame while pressed
        do_reset(12'h400);
        step(18);
        held = '0;
        step(6);
        chk("drop_f4", 32'(keypad), 32'h001);
        held = 12'h400;
        step(6);
        chk("drop_f5", 32'(keypad), 32'h001);
        step(6);
        chk("drop_f6", 32'(keypad), 32'h001);
        chk("drop_presses", 32'(press_cnt), 32'd1);

        chk("exclusive", 32'(excl_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_HOLD, default 2, clocks each column stays driven; the value SHALL be at least 2.
REQ-002 Parameter DEB_SCANS, default 3, consecutive identical full-scan results needed to accept a press or a release.
REQ-003 clk  input  1  1 kHz system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_row  input  4  matrix row sense, active-high, asynchronous to clk.
REQ-006 key_col  output  3  column drive, one-hot, active-high.
REQ-007 keypad  output  10  accepted digit, one-hot: bit n is digit n; held for as long as the key is accepted.
REQ-008 key_star  output  1  '*' accepted, level.
REQ-009 key_hash  output  1  '#' accepted, level.
REQ-010 key_press  output  1  one-clock pulse on each accepted press of any key.

Function
REQ-011 key_row SHALL pass through a single synchronizing register; all sampling SHALL use the synchronized value.
REQ-012 Columns SHALL be driven col0 -> col1 -> col2 -> col0, with each column held for SCAN_HOLD clocks; a full frame is 3*SCAN_HOLD clocks.
REQ-013 Rows SHALL be sampled on the last clock of each column slot.
REQ-014 Key map (row, col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.
REQ-015 Frame result SHALL be NONE if no rows were seen, the 4-bit key code if exactly one key was seen, and MULTI if two or more keys were seen (in any columns).
REQ-016 Frame evaluation SHALL occur on the edge where key_col returns from col2 to col0.
REQ-017 The debounce FSM SHALL have the states IDLE, DEB_PRESS, PRESSED and DEB_REL.
REQ-018 IDLE: a single-key result SHALL latch the candidate code, set the match count to 1 and go to DEB_PRESS; NONE and MULTI SHALL stay in IDLE.
REQ-019 DEB_PRESS: a result equal to the candidate SHALL increment the count; when the count reaches DEB_SCANS the FSM SHALL go to PRESSED.
REQ-020 DEB_PRESS: any other result SHALL return the FSM to IDLE. A different single key SHALL restart the candidate at count 1 within DEB_PRESS.
REQ-021 PRESSED: a result equal to the accepted code SHALL hold the state; any other result (NONE, MULTI or a different key) SHALL go to DEB_REL with count 1.
REQ-022 DEB_REL: a result different from the accepted code SHALL increment the count; DEB_SCANS such results SHALL clear the outputs and go to IDLE.
REQ-023 DEB_REL: a result equal to the accepted code SHALL return the FSM to PRESSED with no new key_press.
REQ-024 On entry to PRESSED from DEB_PRESS, keypad/key_star/key_hash SHALL update on that same edge, and key_press SHALL be high for exactly that cycle.
REQ-025 Latency: a key held from a frame start SHALL be accepted DEB_SCANS*3*SCAN_HOLD clocks later (18 clocks at the defaults).
REQ-026 At most one of the keypad bits, key_star and key_hash SHALL be high at any time.
REQ-027 A change from one key to another SHALL pass through IDLE, so keypad returns to zero before the new key is accepted.
REQ-028 The match counter SHALL saturate at DEB_SCANS and SHALL never wrap.

Reset
REQ-029 Reset values: key_col=3'b001, keypad=0, key_star=0, key_hash=0, key_press=0, FSM=IDLE, counters=0, synchronizer=0.
REQ-030 Reset asserted mid-press SHALL clear all outputs immediately; after release of reset, a still-held key SHALL be fully re-debounced.

Structure
REQ-031 Package keypad_pkg SHALL hold the key code constants (KEY_NONE=0, KEY_0..KEY_9 = 1..10, KEY_STAR=11, KEY_HASH=12, KEY_MULTI=15), the FSM state encoding and the code-to-one-hot function.
REQ-032 The scanner and frame-code logic SHALL live in keypad_scan; the press/release FSM SHALL be the single sub-module keypad_debounce.

Verification
REQ-033 Hold '5' (r1/c1) from a frame start, defaults -> keypad=10'b0000100000 and key_press one cycle at clock 18; released -> keypad=0 18 clocks after the first empty frame.
REQ-034 Bounce '7' present in frame 1, absent in frame 2, present in frames 3-5 -> acceptance at the end of frame 5 only, with a single key_press.
REQ-035 Hold '1' and '9' together -> keypad=0, key_press never asserts; release '9' -> '1' accepted after 3 further frames.
REQ-036 '*' held, then '#' -> key_star=1, then all outputs zero for at least one cycle, then key_hash=1 with a second key_press.
REQ-037 Assert rst 5 clocks after '0' is accepted -> outputs clear asynchronously; with '0' still held after reset, re-acceptance occurs at clock 18.
REQ-038 Key dropped for a single frame while PRESSED -> keypad stays 10'b0000000001 and no extra key_press occurs.
